// File: rtl/nmr_rx_pkg.sv
// Shared constants and FSM encoding for the NMR receiver IQ demodulator.
package nmr_rx_pkg;
  localparam int ADC_LANES = 4;
  localparam int SAMPLE_W  = 16;
  localparam int LO_W      = 16;
  localparam int PIPE_LAT  = 3;
  localparam int PROD_W    = SAMPLE_W + LO_W;
  localparam int LSUM_W    = PROD_W + 2;

  typedef logic [2:0] acq_state_t;
  localparam acq_state_t ST_IDLE    = 3'd0;
  localparam acq_state_t ST_SETTLE  = 3'd1;
  localparam acq_state_t ST_ACQUIRE = 3'd2;
  localparam acq_state_t ST_DRAIN   = 3'd3;
  localparam acq_state_t ST_DONE    = 3'd4;
endpackage

// File: rtl/iq_mixer_lane.sv
// One ADC lane mixed against the I and Q local oscillator; products held until the next accepted beat.
module iq_mixer_lane
  import nmr_rx_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] adc,
  input  logic signed [LO_W-1:0]     lo_i,
  input  logic signed [LO_W-1:0]     lo_q,
  output logic signed [PROD_W-1:0]   prod_i,
  output logic signed [PROD_W-1:0]   prod_q
);
  logic signed [PROD_W-1:0] prod_i_p0_d, prod_i_p0_q;
  logic signed [PROD_W-1:0] prod_q_p0_d, prod_q_p0_q;

  always_comb begin
    prod_i_p0_d = prod_i_p0_q;
    prod_q_p0_d = prod_q_p0_q;
    if (en) begin
      prod_i_p0_d = adc * lo_i;
      prod_q_p0_d = adc * lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_i_p0_q <= '0;
      prod_q_p0_q <= '0;
    end else begin
      prod_i_p0_q <= prod_i_p0_d;
      prod_q_p0_q <= prod_q_p0_d;
    end
  end

  assign prod_i = prod_i_p0_q;
  assign prod_q = prod_q_p0_q;
endmodule

// File: rtl/iq_demodulator.sv
// Four-lane IQ demodulator with block-average decimation and an acquisition FSM.
// Define DEMOD_SAT_EN to clamp the Q15 output instead of letting it wrap.
module iq_demodulator
  import nmr_rx_pkg::*;
#(
  parameter int DEC_LOG2 = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enable_acq,
  input  logic [15:0]                          n_samples,
  input  logic [15:0]                          dead_time,
  input  logic signed [ADC_LANES*SAMPLE_W-1:0] adc_data,
  input  logic                                 adc_valid,
  input  logic signed [ADC_LANES*LO_W-1:0]     LO_I,
  input  logic signed [ADC_LANES*LO_W-1:0]     LO_Q,
  output logic signed [SAMPLE_W-1:0]           I_out,
  output logic signed [SAMPLE_W-1:0]           Q_out,
  output logic                                 sample_valid,
  output logic                                 acq_busy,
  output logic                                 acq_done
);
  localparam int ACC_W = LSUM_W + DEC_LOG2;
  localparam int SHIFT = 17 + DEC_LOG2;
  localparam int RES_W = ACC_W - SHIFT;

`ifdef DEMOD_SAT_EN
  localparam logic signed [RES_W-1:0]    RES_MAX = RES_W'(32767);
  localparam logic signed [RES_W-1:0]    RES_MIN = RES_W'(-32768);
  localparam logic signed [SAMPLE_W-1:0] Q15_MAX = 16'sh7fff;
  localparam logic signed [SAMPLE_W-1:0] Q15_MIN = 16'sh8000;
`endif

  // v is the accumulator already shifted down by SHIFT (block average in Q15).
  function automatic logic signed [SAMPLE_W-1:0] to_q15(input logic signed [RES_W-1:0] v);
`ifdef DEMOD_SAT_EN
    if (v > RES_MAX) return Q15_MAX;
    if (v < RES_MIN) return Q15_MIN;
`endif
    return SAMPLE_W'(v);
  endfunction

  acq_state_t state_d, state_q;
  logic                en_prev_d, en_prev_q;
  logic [15:0]         n_d, n_q, dead_d, dead_q;
  logic [15:0]         settle_cnt_d, settle_cnt_q, samp_cnt_d, samp_cnt_q;
  logic [DEC_LOG2-1:0] beat_cnt_d, beat_cnt_q;
  logic [1:0]          drain_cnt_d, drain_cnt_q;
  logic                acq_done_d, acq_done_q;

  logic start, abort, beat_ok, accept;

  logic signed [PROD_W-1:0] prod_i [ADC_LANES];
  logic signed [PROD_W-1:0] prod_q [ADC_LANES];

  logic                      vld_p0_d, vld_p0_q, first_p0_d, first_p0_q, last_p0_d, last_p0_q;
  logic                      vld_p1_d, vld_p1_q, first_p1_d, first_p1_q, last_p1_d, last_p1_q;
  logic signed [LSUM_W-1:0]  sum_i_p1_d, sum_i_p1_q, sum_q_p1_d, sum_q_p1_q;
  logic                      blk_p2_d, blk_p2_q;
  logic signed [ACC_W-1:0]   acc_i_p2_d, acc_i_p2_q, acc_q_p2_d, acc_q_p2_q;
  logic                      vld_p3_d, vld_p3_q;
  logic signed [SAMPLE_W-1:0] i_out_p3_d, i_out_p3_q, q_out_p3_d, q_out_p3_q;

  assign start   = enable_acq && !en_prev_q;
  assign abort   = !enable_acq && (state_q == ST_SETTLE || state_q == ST_ACQUIRE ||
                                   state_q == ST_DRAIN);
  assign beat_ok = adc_valid && enable_acq;
  assign accept  = beat_ok && (state_q == ST_ACQUIRE);

  always_comb begin
    state_d      = state_q;
    en_prev_d    = enable_acq;
    n_d          = n_q;
    dead_d       = dead_q;
    settle_cnt_d = settle_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    acq_done_d   = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d          = n_samples;
          dead_d       = dead_time;
          settle_cnt_d = '0;
          samp_cnt_d   = '0;
          beat_cnt_d   = '0;
          if (n_samples == 16'd0)      state_d = ST_DONE;
          else if (dead_time == 16'd0) state_d = ST_ACQUIRE;
          else                         state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (beat_ok) begin
          if (settle_cnt_q == dead_q - 16'd1) state_d = ST_ACQUIRE;
          else settle_cnt_d = settle_cnt_q + 16'd1;
        end
      end
      ST_ACQUIRE: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (&beat_cnt_q) begin
            samp_cnt_d = samp_cnt_q + 16'd1;
            if (samp_cnt_q == n_q - 16'd1) begin
              state_d     = ST_DRAIN;
              drain_cnt_d = '0;
            end
          end
        end
      end
      ST_DRAIN: begin
        // Hold until the last block has reached the output register.
        if (drain_cnt_q == 2'(PIPE_LAT - 1)) state_d = ST_DONE;
        else drain_cnt_d = drain_cnt_q + 2'd1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  for (genvar k = 0; k < ADC_LANES; k++) begin : g_lane
    iq_mixer_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (accept),
      .adc    (adc_data[k*SAMPLE_W +: SAMPLE_W]),
      .lo_i   (LO_I[k*LO_W +: LO_W]),
      .lo_q   (LO_Q[k*LO_W +: LO_W]),
      .prod_i (prod_i[k]),
      .prod_q (prod_q[k])
    );
  end

  always_comb begin
    // p0: lane products registered inside the mixer lanes
    vld_p0_d   = accept;
    first_p0_d = (beat_cnt_q == '0);
    last_p0_d  = &beat_cnt_q;
    // p1: four-lane sum; an abort squashes every in-flight valid
    vld_p1_d   = vld_p0_q && !abort;
    first_p1_d = first_p0_q;
    last_p1_d  = last_p0_q;
    sum_i_p1_d = sum_i_p1_q;
    sum_q_p1_d = sum_q_p1_q;
    if (vld_p0_q) begin
      sum_i_p1_d = '0;
      sum_q_p1_d = '0;
      for (int k = 0; k < ADC_LANES; k++) begin
        sum_i_p1_d = sum_i_p1_d + LSUM_W'(prod_i[k]);
        sum_q_p1_d = sum_q_p1_d + LSUM_W'(prod_q[k]);
      end
    end
    // p2: block accumulator
    blk_p2_d   = vld_p1_q && last_p1_q && !abort;
    acc_i_p2_d = acc_i_p2_q;
    acc_q_p2_d = acc_q_p2_q;
    if (vld_p1_q) begin
      acc_i_p2_d = first_p1_q ? ACC_W'(sum_i_p1_q) : acc_i_p2_q + ACC_W'(sum_i_p1_q);
      acc_q_p2_d = first_p1_q ? ACC_W'(sum_q_p1_q) : acc_q_p2_q + ACC_W'(sum_q_p1_q);
    end
    // p3: output register
    vld_p3_d   = blk_p2_q && !abort;
    i_out_p3_d = i_out_p3_q;
    q_out_p3_d = q_out_p3_q;
    if (blk_p2_q) begin
      i_out_p3_d = to_q15(acc_i_p2_q[ACC_W-1:SHIFT]);
      q_out_p3_d = to_q15(acc_q_p2_q[ACC_W-1:SHIFT]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      en_prev_q    <= 1'b1;  // a level held high through reset is not a fresh start
      n_q          <= '0;
      dead_q       <= '0;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      acq_done_q   <= 1'b0;
      vld_p0_q     <= 1'b0;
      first_p0_q   <= 1'b0;
      last_p0_q    <= 1'b0;
      vld_p1_q     <= 1'b0;
      first_p1_q   <= 1'b0;
      last_p1_q    <= 1'b0;
      sum_i_p1_q   <= '0;
      sum_q_p1_q   <= '0;
      blk_p2_q     <= 1'b0;
      acc_i_p2_q   <= '0;
      acc_q_p2_q   <= '0;
      vld_p3_q     <= 1'b0;
      i_out_p3_q   <= '0;
      q_out_p3_q   <= '0;
    end else begin
      state_q      <= state_d;
      en_prev_q    <= en_prev_d;
      n_q          <= n_d;
      dead_q       <= dead_d;
      settle_cnt_q <= settle_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      acq_done_q   <= acq_done_d;
      vld_p0_q     <= vld_p0_d;
      first_p0_q   <= first_p0_d;
      last_p0_q    <= last_p0_d;
      vld_p1_q     <= vld_p1_d;
      first_p1_q   <= first_p1_d;
      last_p1_q    <= last_p1_d;
      sum_i_p1_q   <= sum_i_p1_d;
      sum_q_p1_q   <= sum_q_p1_d;
      blk_p2_q     <= blk_p2_d;
      acc_i_p2_q   <= acc_i_p2_d;
      acc_q_p2_q   <= acc_q_p2_d;
      vld_p3_q     <= vld_p3_d;
      i_out_p3_q   <= i_out_p3_d;
      q_out_p3_q   <= q_out_p3_d;
    end
  end

  assign I_out        = i_out_p3_q;
  assign Q_out        = q_out_p3_q;
  assign sample_valid = vld_p3_q;
  assign acq_busy     = (state_q != ST_IDLE);
  assign acq_done     = acq_done_q;
endmodule

// File: tb/tb_iq_demodulator.sv
// Scoreboard bench for iq_demodulator: randomized beats against a plain-arithmetic block-average model.
`timescale 1ns/1ps
module tb_iq_demodulator;
  localparam int DEC_LOG2 = 4;
  localparam int BLK      = 1 << DEC_LOG2;
  localparam int LAT      = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_acq;
  logic [15:0] n_samples, dead_time;
  logic signed [63:0] adc_data, lo_i, lo_q;
  logic        adc_valid;
  logic signed [15:0] i_out, q_out;
  logic        sample_valid, acq_busy, acq_done;

  iq_demodulator #(.DEC_LOG2(DEC_LOG2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_acq   (enable_acq),
    .n_samples    (n_samples),
    .dead_time    (dead_time),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .LO_I         (lo_i),
    .LO_Q         (lo_q),
    .I_out        (i_out),
    .Q_out        (q_out),
    .sample_valid (sample_valid),
    .acq_busy     (acq_busy),
    .acq_done     (acq_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
    int                 edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, failures = 0;
  int strobe_cnt = 0, done_cnt = 0, last_strobe_edge = 0, done_edge = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Block average in Q15: sum over the block of all lane products, divided by 2^(17+DEC_LOG2).
  function automatic logic signed [15:0] model_q15(input longint acc);
    longint r;
    r = acc >>> (17 + DEC_LOG2);
`ifdef DEMOD_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  always @(negedge clk) begin
    if (sample_valid) begin
      strobe_cnt++;
      last_strobe_edge = cyc;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got I=%0d Q=%0d at cycle %0d, expected no strobe", i_out, q_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("I_out", i_out, mon_e.i);
        chk("Q_out", q_out, mon_e.q);
        chk("strobe_edge", cyc, mon_e.edge_n);
      end
    end
    if (acq_done) begin
      done_cnt++;
      done_edge = cyc;
      chk("done_not_with_strobe", sample_valid, 0);
      chk("done_after_all_strobes", sb.size(), 0);
    end
  end

  task automatic gen_beat(input int dmode, output longint bi, output longint bq);
    logic signed [15:0] a, li, lq;
    bi = 0;
    bq = 0;
    for (int k = 0; k < 4; k++) begin
      case (dmode)
        1:       begin a = 16'sd16384;  li = 16'sd32767;  lq = 16'sd0;     end
        2:       begin a = 16'sh8000;   li = 16'sh8000;   lq = 16'sd16384; end
        default: begin a = 16'($urandom); li = 16'($urandom); lq = 16'($urandom); end
      endcase
      adc_data[k*16 +: 16] = a;
      lo_i[k*16 +: 16]     = li;
      lo_q[k*16 +: 16]     = lq;
      bi += longint'(a) * longint'(li);
      bq += longint'(a) * longint'(lq);
    end
  endtask

  // vmode: 0 valid every cycle, 1 toggling 1/0, 2 random ~70%.
  task automatic run_acq(input int n, input int dead, input int dmode, input int vmode, input int abort_at);
    int total, vcount, it, idx, done0, str0, start_edge, w;
    longint ai, aq, bi, bq;
    logic v;
    total = dead + n * BLK;
    vcount = 0; it = 0; ai = 0; aq = 0;
    done0 = done_cnt;
    str0 = strobe_cnt;
    n_samples = 16'(n);
    dead_time = 16'(dead);
    enable_acq = 1'b1;
    adc_valid = 1'b0;
    @(posedge clk); #1;
    start_edge = cyc;
    chk("busy_after_start", acq_busy, 1);
    while (vcount < total + 4) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (it % 2 == 0);
        default: v = ($urandom_range(0, 9) < 7);
      endcase
      it++;
      gen_beat(dmode, bi, bq);
      adc_valid = v;
      if (v) begin
        if (vcount >= dead && vcount < total) begin
          idx = vcount - dead;
          if (idx % BLK == 0) begin ai = bi; aq = bq; end
          else begin ai += bi; aq += bq; end
          if (idx % BLK == BLK - 1) sb.push_back('{model_q15(ai), model_q15(aq), cyc + 1 + LAT});
        end
        vcount++;
      end
      @(posedge clk); #1;
      if (abort_at >= 0 && vcount - dead == abort_at) break;
    end
    if (abort_at >= 0) begin
      enable_acq = 1'b0;
      adc_valid = 1'b0;
      @(posedge clk); #1;
      chk("busy_low_after_abort", acq_busy, 0);
      repeat (8) @(posedge clk);
      #1;
      chk("no_done_after_abort", done_cnt - done0, 0);
      chk("no_strobe_after_abort", strobe_cnt - str0, 0);
      return;
    end
    w = 0;
    while (sb.size() != 0 && w < 64) begin @(posedge clk); #1; w++; end
    chk("scoreboard_drained", sb.size(), 0);
    w = 0;
    while (done_cnt == done0 && w < 16) begin @(posedge clk); #1; w++; end
    chk("done_count", done_cnt - done0, 1);
    chk("strobe_count", strobe_cnt - str0, n);
    if (n == 0) chk("done_edge_after_start", done_edge - start_edge, 1);
    else begin
      checks++;
      if (!(done_edge > last_strobe_edge && done_edge - last_strobe_edge <= 3)) begin
        failures++;
        $display("FAIL done_timing: done at cycle %0d, last strobe at %0d, expected 1..3 cycles later",
                 done_edge, last_strobe_edge);
      end
    end
    adc_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_retrigger_while_high", acq_busy, 0);
    enable_acq = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_I_out"}, i_out, 0);
    chk({tag, "_Q_out"}, q_out, 0);
    chk({tag, "_sample_valid"}, sample_valid, 0);
    chk({tag, "_acq_busy"}, acq_busy, 0);
    chk({tag, "_acq_done"}, acq_done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    longint bi, bq;
    int str0;
    rst_n = 1'b0;
    enable_acq = 1'b0;
    adc_valid = 1'b0;
    adc_data = '0;
    lo_i = '0;
    lo_q = '0;
    n_samples = '0;
    dead_time = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_acq(2, 0, 1, 0, -1);
    run_acq(1, 5, 0, 1, -1);
    run_acq(1, 0, 2, 0, -1);
    run_acq(2, 0, 0, 2, 10);
    run_acq(1, 0, 0, 0, -1);
    run_acq(0, 3, 0, 0, -1);
    for (int r = 0; r < 5; r++)
      run_acq($urandom_range(1, 3), $urandom_range(0, 6), 0, 2, -1);

    // Reset in the middle of a block, enable kept high across release.
    n_samples = 16'd2;
    dead_time = 16'd0;
    enable_acq = 1'b1;
    @(posedge clk); #1;
    repeat (12) begin
      gen_beat(0, bi, bq);
      adc_valid = 1'b1;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    str0 = strobe_cnt;
    repeat (40) begin
      gen_beat(0, bi, bq);
      adc_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("busy_after_reset_release", acq_busy, 0);
    chk("no_strobe_after_reset", strobe_cnt - str0, 0);
    enable_acq = 1'b0;
    adc_valid = 1'b0;
    @(posedge clk); #1;

    run_acq(2, 2, 0, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
